// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and master IDs for the peripheral bus arbiter
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request/ack signals plus the shared bus strobes
interface bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ack;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ack;
   logic [DATA_W-1:0] m1_rdata;

   logic              MemRead;
   logic              MemWrite;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] Write_data;
   logic [DATA_W-1:0] Read_data;

   // Arbiter side: takes requests and bus read data, drives acks and strobes
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  Read_data,
      output m0_ack, m0_rdata, m1_ack, m1_rdata,
      output MemRead, MemWrite, Address, Write_data
   );

   // Environment side: the two masters plus the bus returning read data
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output Read_data,
      input  m0_ack, m0_rdata, m1_ack, m1_rdata,
      input  MemRead, MemWrite, Address, Write_data
   );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way grant with round-robin or fixed tie-break
module rr_arbiter2
   import bus_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   input  logic       i_fixed_prio,
   output logic [1:0] o_grant,
   output logic       o_grant_id
);

   // A lone requester wins; a tie goes to master 0 unless round-robin says it won last
   always_comb begin
      o_grant_id = M_CPU;
      if (i_req == 2'b10) begin
         o_grant_id = M_DMA;
      end else if (i_req == 2'b11 && !i_fixed_prio && i_last_grant == M_CPU) begin
         o_grant_id = M_DMA;
      end
      o_grant = 2'b00;
      if (i_req != 2'b00) begin
         o_grant = o_grant_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - serialises single-word transfers from two masters onto the peripheral bus
module bus_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input logic          clk,
   input logic          reset,
   bus_arbiter_if.slave bus
);
   import bus_arb_pkg::*;

   state_t            r_state;
   logic              r_owner;
   logic              r_last_grant;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [ADDR_W-1:0] r_address;
   logic [DATA_W-1:0] r_write_data;
   logic              r_m0_ack;
   logic              r_m1_ack;
   logic [DATA_W-1:0] r_m0_rdata;
   logic [DATA_W-1:0] r_m1_rdata;

   logic [1:0]        w_req;
   logic [1:0]        w_grant;
   logic              w_grant_id;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   assign w_req = {bus.m1_req, bus.m0_req};

   rr_arbiter2 u_rr (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .i_fixed_prio (FIXED_PRIO != 0),
      .o_grant      (w_grant),
      .o_grant_id   (w_grant_id)
   );

   assign w_sel_we    = w_grant[1] ? bus.m1_we    : bus.m0_we;
   assign w_sel_addr  = w_grant[1] ? bus.m1_addr  : bus.m0_addr;
   assign w_sel_wdata = w_grant[1] ? bus.m1_wdata : bus.m0_wdata;

   // IDLE -> ACCESS -> RESP; strobes and acks default low so each pulses exactly one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= M_CPU;
         r_last_grant <= M_DMA;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_address    <= '0;
         r_write_data <= '0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_m0_rdata   <= '0;
         r_m1_rdata   <= '0;
      end else begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_m0_ack    <= 1'b0;
         r_m1_ack    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req != 2'b00) begin
                  r_owner      <= w_grant_id;
                  r_last_grant <= w_grant_id;
                  r_address    <= w_sel_addr;
                  r_write_data <= w_sel_wdata;
                  r_mem_read   <= !w_sel_we;
                  r_mem_write  <= w_sel_we;
                  r_state      <= ACCESS;
               end
            end
            ACCESS: begin
               // Only the owner's rdata moves, and only on a read
               if (r_mem_read) begin
                  if (r_owner == M_DMA) begin
                     r_m1_rdata <= bus.Read_data;
                  end else begin
                     r_m0_rdata <= bus.Read_data;
                  end
               end
               if (r_owner == M_DMA) begin
                  r_m1_ack <= 1'b1;
               end else begin
                  r_m0_ack <= 1'b1;
               end
               r_state <= RESP;
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.MemRead    = r_mem_read;
   assign bus.MemWrite   = r_mem_write;
   assign bus.Address    = r_address;
   assign bus.Write_data = r_write_data;
   assign bus.m0_ack     = r_m0_ack;
   assign bus.m1_ack     = r_m1_ack;
   assign bus.m0_rdata   = r_m0_rdata;
   assign bus.m1_rdata   = r_m1_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a transfer-level model
module tb_bus_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic ram_clr;
   int   n_cmp = 0;
   int   n_err = 0;
   int   strobe_viol = 0;
   int   ack_viol = 0;

   bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi0 ();
   bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bi1 ();

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (bi0.slave)
   );

   bus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
      .clk   (clk),
      .reset (reset),
      .bus   (bi1.slave)
   );

   always #5 clk = ~clk;

   // Bus model: 256-word RAM in the low region, a single peripheral register elsewhere
   logic [31:0] ram [0:255];
   logic [31:0] periph_data;

   always_comb bi0.Read_data = (bi0.Address[31:30] == 2'b00) ? ram[bi0.Address[9:2]] : 32'h0BAD_0000;
   assign bi1.Read_data = 32'h0;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      end else if (bi0.MemWrite) begin
         if (bi0.Address[31:30] == 2'b00) ram[bi0.Address[9:2]] <= bi0.Write_data;
         else periph_data <= bi0.Write_data;
      end
   end

   // Exclusivity monitors for strobes and acks on both instances
   always @(negedge clk) begin
      if ((bi0.MemRead && bi0.MemWrite) || (bi1.MemRead && bi1.MemWrite)) strobe_viol++;
      if ((bi0.m0_ack && bi0.m1_ack) || (bi1.m0_ack && bi1.m1_ack)) ack_viol++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int m, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         bi0.m0_req = req; bi0.m0_we = we; bi0.m0_addr = addr; bi0.m0_wdata = wdata;
      end else begin
         bi0.m1_req = req; bi0.m1_we = we; bi0.m1_addr = addr; bi0.m1_wdata = wdata;
      end
   endtask

   function automatic logic [31:0] acks0();
      return {30'h0, bi0.m1_ack, bi0.m0_ack};
   endfunction

   function automatic logic [31:0] strobes0();
      return {30'h0, bi0.MemRead, bi0.MemWrite};
   endfunction

   logic [31:0] model_mem [0:255];
   logic [31:0] model_rdata [0:1];
   int          last_g;

   task automatic do_reset();
      reset = 1'b1; ram_clr = 1'b1;
      step(); step();
      reset = 1'b0; ram_clr = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
      model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;
      last_g = 1;
   endtask

   initial begin
      logic [1:0]  mask;
      logic        we_r [0:1];
      int          idx_r [0:1];
      logic [31:0] wd_r [0:1];
      logic [31:0] exp_ack;
      int          n_tr, first, second, nsteps, cur;
      int          cyc, prev, exp_w, n0, m1_seen, lat, seen;

      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      bi1.m0_req = 1'b0; bi1.m0_we = 1'b0; bi1.m0_addr = 32'h0; bi1.m0_wdata = 32'h0;
      bi1.m1_req = 1'b0; bi1.m1_we = 1'b0; bi1.m1_addr = 32'h0; bi1.m1_wdata = 32'h0;
      reset = 1'b1; ram_clr = 1'b1;
      step(); step();
      check("rst_strobes", strobes0(), 32'h0);
      check("rst_acks", acks0(), 32'h0);
      check("rst_addr", bi0.Address, 32'h0);
      check("rst_wdata", bi0.Write_data, 32'h0);
      check("rst_rdata", bi0.m0_rdata | bi0.m1_rdata, 32'h0);
      reset = 1'b0; ram_clr = 1'b0;
      last_g = 1;

      // DMA preloads RAM word 0x10
      drive(1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
      step();
      check("pre_strobe", strobes0(), 32'h1);
      check("pre_addr", bi0.Address, 32'h10);
      step();
      check("pre_ack", acks0(), 32'h2);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Single read by master 0
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      step();
      check("rd_strobe", strobes0(), 32'h2);
      step();
      check("rd_strobe_off", strobes0(), 32'h0);
      check("rd_ack", acks0(), 32'h1);
      check("rd_data", bi0.m0_rdata, 32'hDEAD_BEEF);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      check("rd_ack_width", acks0(), 32'h0);
      check("rd_hold", bi0.m0_rdata, 32'hDEAD_BEEF);

      // Peripheral write by master 1 leaves master 0's rdata alone
      drive(1, 1'b1, 1'b1, 32'h4000_0010, 32'h0000_1234);
      step();
      check("bcd_strobe", strobes0(), 32'h1);
      check("bcd_addr", bi0.Address, 32'h4000_0010);
      check("bcd_wdata", bi0.Write_data, 32'h0000_1234);
      step();
      check("bcd_ack", acks0(), 32'h2);
      check("bcd_m0_iso", bi0.m0_rdata, 32'hDEAD_BEEF);
      check("bcd_m1_rdata", bi0.m1_rdata, 32'h0);
      check("bcd_periph", periph_data, 32'h0000_1234);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Back-to-back: req held through ack; one idle cycle, then the next ACCESS
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      step(); step();
      check("b2b_ack1", acks0(), 32'h1);
      drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
      step();
      check("b2b_gap", strobes0() | acks0(), 32'h0);
      step();
      check("b2b_strobe", strobes0(), 32'h2);
      check("b2b_addr", bi0.Address, 32'h14);
      step();
      check("b2b_ack2", acks0(), 32'h1);
      check("b2b_data", bi0.m0_rdata, 32'h0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Round-robin under sustained contention from reset, plus fixed priority on the second instance
      do_reset();
      drive(0, 1'b1, 1'b1, 32'h20, 32'hA000_0000);
      drive(1, 1'b1, 1'b1, 32'h24, 32'hB000_0000);
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b1; bi1.m0_addr = 32'h30; bi1.m0_wdata = 32'h1;
      bi1.m1_req = 1'b1; bi1.m1_we = 1'b1; bi1.m1_addr = 32'h34; bi1.m1_wdata = 32'h2;
      cyc = 0; prev = 0; n0 = 0; m1_seen = 0;
      for (int k = 0; k < 8; k++) begin
         exp_w = (last_g == 0) ? 1 : 0;
         for (int w = 0; w < 4; w++) begin
            step(); cyc++;
            if (bi1.m1_ack) m1_seen++;
            if (bi1.m0_ack) n0++;
            if (acks0() != 32'h0) break;
         end
         check($sformatf("rr_order%0d", k), acks0(), (exp_w == 1) ? 32'h2 : 32'h1);
         if (k == 0) check("rr_first_lat", 32'(cyc), 32'd2);
         else check($sformatf("rr_spacing%0d", k), 32'(cyc - prev), 32'd3);
         prev = cyc;
         last_g = exp_w;
         drive(exp_w, 1'b1, 1'b1, 32'(32'h40 + 8 * k + 4 * exp_w), $urandom);
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("fp_m0_served", 32'(n0 >= 5 ? 1 : 0), 32'h1);
      check("fp_m1_starved", 32'(m1_seen), 32'h0);
      // Drop master 0 right after its next ack; master 1 then gets through in 3 cycles
      seen = 0;
      for (int w = 0; w < 4 && seen == 0; w++) begin
         step();
         if (bi1.m1_ack) m1_seen++;
         if (bi1.m0_ack) seen = 1;
      end
      check("fp_m0_next_ack", 32'(seen), 32'h1);
      bi1.m0_req = 1'b0;
      lat = 0; seen = 0;
      for (int w = 0; w < 6 && seen == 0; w++) begin
         step(); lat++;
         if (bi1.m1_ack) seen = 1;
      end
      check("fp_m1_starved_late", 32'(m1_seen), 32'h0);
      check("fp_m1_latency", 32'(lat), 32'd3);
      bi1.m1_req = 1'b0;
      step(); step();

      // Reset during a read's ACCESS cycle aborts it and restores master 0 tie priority
      drive(1, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D);
      step(); step();
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      step();
      check("rstacc_strobe", strobes0(), 32'h2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      check("rstacc_outs", strobes0() | acks0(), 32'h0);
      check("rstacc_addr", bi0.Address, 32'h0);
      check("rstacc_rdata", bi0.m0_rdata, 32'h0);
      seen = 0;
      for (int w = 0; w < 3; w++) begin
         step();
         if (acks0() != 32'h0) seen = 1;
      end
      check("rstacc_no_ack", 32'(seen), 32'h0);
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
      step(); step();
      check("rstacc_tie_m0", acks0(), 32'h1);
      check("rstacc_m0_data", bi0.m0_rdata, 32'hCAFE_F00D);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(); step(); step();
      check("rstacc_tie_m1", acks0(), 32'h2);
      check("rstacc_m1_data", bi0.m1_rdata, 32'hCAFE_F00D);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Randomized rounds: transfer-level model predicts grant order, ack timing and rdata
      do_reset();
      for (int r = 0; r < 40; r++) begin
         mask = 2'($urandom_range(1, 3));
         for (int m = 0; m < 2; m++) begin
            we_r[m]  = 1'($urandom_range(0, 1));
            idx_r[m] = int'($urandom_range(0, 15));
            wd_r[m]  = $urandom;
            if (mask[m]) drive(m, 1'b1, we_r[m], 32'(idx_r[m] * 4), wd_r[m]);
         end
         n_tr   = (mask == 2'b11) ? 2 : 1;
         first  = (mask == 2'b11) ? ((last_g == 0) ? 1 : 0) : (mask[1] ? 1 : 0);
         second = 1 - first;
         nsteps = (n_tr == 2) ? 6 : 3;
         for (int t = 1; t <= nsteps; t++) begin
            step();
            exp_ack = 32'h0;
            cur = -1;
            if (t == 2) cur = first;
            if (t == 5 && n_tr == 2) cur = second;
            if (cur >= 0) begin
               exp_ack = (cur == 1) ? 32'h2 : 32'h1;
               if (we_r[cur]) model_mem[idx_r[cur]] = wd_r[cur];
               else model_rdata[cur] = model_mem[idx_r[cur]];
               last_g = cur;
               drive(cur, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            check($sformatf("rnd%0d_ack_t%0d", r, t), acks0(), exp_ack);
            if (cur >= 0) begin
               check($sformatf("rnd%0d_rdata0", r), bi0.m0_rdata, model_rdata[0]);
               check($sformatf("rnd%0d_rdata1", r), bi0.m1_rdata, model_rdata[1]);
            end
         end
      end

      check("strobe_excl", 32'(strobe_viol), 32'h0);
      check("ack_excl", 32'(ack_viol), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
